// File: rtl/pds_pkg.sv
// Shared types and widths for the PSE port power scheduler.
package pds_pkg;

   localparam int unsigned PWR_W  = 12;
   localparam int unsigned PRIO_W = 2;

   typedef enum logic [1:0] {IDLE, STAGGER, SHED} pds_sched_state_e;

   typedef logic [PRIO_W-1:0] prio_t;

endpackage

// File: rtl/pds_prio_pick.sv
// Combinational priority selector: one-hot of the best (lowest index on tie) or,
// with lowest=1, the worst (highest index on tie) member of mask.
module pds_prio_pick
   import pds_pkg::*;
#(
   parameter int unsigned NUM_PORTS = 4
) (
   input  logic [NUM_PORTS-1:0]        mask,
   input  logic [PRIO_W*NUM_PORTS-1:0] prio,
   input  logic                        lowest,
   output logic [NUM_PORTS-1:0]        pick_c
);

   prio_t sel_p;
   prio_t cur_p;
   logic  found;

   // Strict compare keeps the earlier index for best; <= lets a later index win for worst.
   always_comb begin
      pick_c = '0;
      sel_p  = '0;
      cur_p  = '0;
      found  = 1'b0;
      for (int i = 0; i < int'(NUM_PORTS); i++) begin
         cur_p = prio[PRIO_W*i +: PRIO_W];
         if (mask[i] && (!found || (lowest ? (cur_p <= sel_p) : (cur_p > sel_p)))) begin
            pick_c    = '0;
            pick_c[i] = 1'b1;
            sel_p     = cur_p;
            found     = 1'b1;
         end
      end
   end

endmodule

// File: rtl/pds_port_scheduler.sv
// PSE port power scheduler: staggered admission and budget shedding.
// Define PDS_PREEMPT_EN to let a higher-priority waiting port displace a lower one.
module pds_port_scheduler
   import pds_pkg::*;
#(
   parameter int unsigned NUM_PORTS      = 4,
   parameter int unsigned PORT_PWR       = 15,
   parameter int unsigned STAGGER_CYCLES = 8
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic [NUM_PORTS-1:0]        det,
   input  logic [NUM_PORTS-1:0]        off,
   input  logic [PRIO_W*NUM_PORTS-1:0] prio,
   input  logic [7:0]                  pwr_bdj,
   input  logic                        ports_off,
   output logic [NUM_PORTS-1:0]        on,
   output logic [PWR_W-1:0]            pwr_used,
   output logic                        shed_evt
);

   localparam int unsigned      CNT_W      = $clog2(STAGGER_CYCLES + 1);
   localparam logic [PWR_W-1:0] PORT_PWR_W = PWR_W'(PORT_PWR);

   pds_sched_state_e     state;
   logic [CNT_W-1:0]     cnt;
   logic [NUM_PORTS-1:0] elig;
   logic [NUM_PORTS-1:0] on_kept;
   logic [NUM_PORTS-1:0] cand;
   logic [NUM_PORTS-1:0] adm_pick;
   logic [NUM_PORTS-1:0] shed_pick;
   logic [PWR_W-1:0]     used_k;
   logic [PWR_W-1:0]     bdj;
   logic                 over;
   logic                 fits;
   logic                 shed_last;
   logic                 preempt;

   function automatic logic [PWR_W-1:0] pwr_of(input logic [NUM_PORTS-1:0] v);
      logic [PWR_W-1:0] n;
      n = '0;
      for (int i = 0; i < int'(NUM_PORTS); i++) n = n + PWR_W'(v[i]);
      return n * PORT_PWR_W;
   endfunction

   // Ports losing eligibility are dropped before any budget decision is made.
   assign elig      = det & ~off & {NUM_PORTS{~ports_off}};
   assign on_kept   = on & elig;
   assign cand      = elig & ~on;
   assign used_k    = pwr_of(on_kept);
   assign pwr_used  = pwr_of(on);
   assign bdj       = PWR_W'(pwr_bdj);
   assign over      = used_k > bdj;
   assign fits      = (used_k + PORT_PWR_W) <= bdj;
   assign shed_last = (used_k - PORT_PWR_W) <= bdj;

   pds_prio_pick #(.NUM_PORTS(NUM_PORTS)) u_adm_pick (
      .mask   (cand),
      .prio   (prio),
      .lowest (1'b0),
      .pick_c (adm_pick)
   );

   pds_prio_pick #(.NUM_PORTS(NUM_PORTS)) u_shed_pick (
      .mask   (on_kept),
      .prio   (prio),
      .lowest (1'b1),
      .pick_c (shed_pick)
   );

`ifdef PDS_PREEMPT_EN
   prio_t adm_p;
   prio_t shed_p;

   always_comb begin
      adm_p  = '0;
      shed_p = '0;
      for (int i = 0; i < int'(NUM_PORTS); i++) begin
         if (adm_pick[i])  adm_p  = prio[PRIO_W*i +: PRIO_W];
         if (shed_pick[i]) shed_p = prio[PRIO_W*i +: PRIO_W];
      end
   end

   // Removing one port always frees room for one, so only the priority test remains.
   assign preempt = (|adm_pick) && !fits && (|shed_pick) && (shed_p < adm_p);
`else
   assign preempt = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         cnt      <= '0;
         on       <= '0;
         shed_evt <= 1'b0;
      end else begin
         shed_evt <= 1'b0;
         on       <= on_kept;
         if (ports_off) begin
            state <= IDLE;
            cnt   <= '0;
         end else begin
            case (state)
               IDLE: begin
                  if (over) begin
                     state <= SHED;
                  end else if ((|adm_pick) && fits) begin
                     on    <= on_kept | adm_pick;
                     cnt   <= CNT_W'(STAGGER_CYCLES - 1);
                     state <= STAGGER;
                  end else if (preempt) begin
                     on       <= (on_kept & ~shed_pick) | adm_pick;
                     shed_evt <= 1'b1;
                     cnt      <= CNT_W'(STAGGER_CYCLES - 1);
                     state    <= STAGGER;
                  end
               end
               STAGGER: begin
                  if (over) begin
                     state <= SHED;
                     cnt   <= '0;
                  end else if (cnt == '0) begin
                     state <= IDLE;
                  end else begin
                     cnt <= cnt - CNT_W'(1);
                  end
               end
               SHED: begin
                  if (|on_kept) begin
                     on       <= on_kept & ~shed_pick;
                     shed_evt <= 1'b1;
                     if (shed_last) state <= IDLE;
                  end else begin
                     state <= IDLE;
                  end
               end
               default: state <= IDLE;
            endcase
         end
      end
   end

endmodule
